msg_writer: RTL and testbench



---
 rtl/char_code_pkg.sv | 30 +++
 rtl/char_check.sv | 19 +
 rtl/msg_writer.sv | 112 +++++++++++
 tb/tb_msg_writer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/char_code_pkg.sv
// Shared character-code definitions for the display character path.
// Holds the 3-bit character codes, buffer geometry, the blank bus
// pattern and the msg_writer state encoding.
package char_code_pkg;

    localparam int unsigned CHAR_W = 3;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned BUS_W  = CHAR_W * DEPTH;
    localparam int unsigned LEN_W  = 4;

    localparam logic [CHAR_W-1:0] CH_H     = 3'b000;
    localparam logic [CHAR_W-1:0] CH_E     = 3'b001;
    localparam logic [CHAR_W-1:0] CH_L     = 3'b010;
    localparam logic [CHAR_W-1:0] CH_O     = 3'b011;
    localparam logic [CHAR_W-1:0] CH_BLANK = 3'b100;

    // Every slot holding CH_BLANK
    localparam logic [BUS_W-1:0] BLANK_BUS = 24'h924924;

    typedef enum logic {
        ST_LOAD   = 1'b0,
        ST_SCROLL = 1'b1
    } state_e;

    // Codes above CH_BLANK have no glyph
    function automatic logic code_is_valid(input logic [CHAR_W-1:0] code);
        return code <= CH_BLANK;
    endfunction

endpackage

// File: rtl/char_check.sv
// char_check: combinational sanitiser for incoming character codes.
// Codes with no glyph are replaced by blank and flagged.
// Ports: code_i (raw code), code_o (code to store), invalid_o (code had no glyph).
// The module only exists when MSG_WRITER_CHECK_EN is defined, so the default
// build carries no unused module.
`ifdef MSG_WRITER_CHECK_EN
module char_check
    import char_code_pkg::*;
(
    input  logic [CHAR_W-1:0] code_i,
    output logic [CHAR_W-1:0] code_o,
    output logic              invalid_o
);

    assign invalid_o = !code_is_valid(code_i);
    assign code_o    = invalid_o ? CH_BLANK : code_i;

endmodule
`endif

// File: rtl/msg_writer.sv
// msg_writer: loads a message of 3-bit character codes into an 8-slot
// display buffer through a valid/ready port, then rotates it left one slot
// per scroll tick. Slot k drives char_bus[3k+2:3k]; slot 7 is the leftmost digit.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   wr_valid/wr_char/wr_last/wr_ready   character write port
//   tick              one-cycle scroll strobe
//   clear             blank buffer, return to LOAD (err kept)
//   char_bus          per-digit character codes
//   msg_len           characters accepted (0..8)
//   scrolling         high in SCROLL
//   err               sticky invalid-code flag
// Build option: MSG_WRITER_CHECK_EN blanks codes 101..111 and sets err;
// without it codes are stored raw and err stays 0.
module msg_writer
    import char_code_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [CHAR_W-1:0] wr_char,
    input  logic              wr_last,
    output logic              wr_ready,
    input  logic              tick,
    input  logic              clear,
    output logic [BUS_W-1:0]  char_bus,
    output logic [LEN_W-1:0]  msg_len,
    output logic              scrolling,
    output logic              err
);

    state_e             state_q, state_d;
    logic [BUS_W-1:0]   bus_q, bus_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               err_q, err_d;

    logic [CHAR_W-1:0]  store_char;
    logic               bad_char;
    logic [2:0]         wr_slot;
    logic [4:0]         wr_base;

    // Code sanitising
`ifdef MSG_WRITER_CHECK_EN
    char_check u_char_check (
        .code_i    (wr_char),
        .code_o    (store_char),
        .invalid_o (bad_char)
    );
`else
    assign store_char = wr_char;
    assign bad_char   = 1'b0;
`endif

    // Characters fill from the leftmost slot down
    assign wr_slot = 3'(LEN_W'(DEPTH - 1) - len_q);
    assign wr_base = 5'(wr_slot) * 5'(CHAR_W);

    // State and buffer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOAD;
            bus_q   <= BLANK_BUS;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    // Next state: clear beats writes and ticks
    always_comb begin
        state_d = state_q;
        bus_d   = bus_q;
        len_d   = len_q;
        err_d   = err_q;
        if (clear) begin
            state_d = ST_LOAD;
            bus_d   = BLANK_BUS;
            len_d   = '0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    if (wr_valid) begin
                        bus_d[wr_base +: CHAR_W] = store_char;
                        len_d = len_q + LEN_W'(1);
                        err_d = err_q | bad_char;
                        if (wr_last || (len_q == LEN_W'(DEPTH - 1))) begin
                            state_d = ST_SCROLL;
                        end
                    end
                end
                ST_SCROLL: begin
                    // Rotate left: slot k moves to k+1, slot 7 wraps to 0
                    if (tick) begin
                        bus_d = {bus_q[BUS_W-CHAR_W-1:0], bus_q[BUS_W-1 -: CHAR_W]};
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end
    end

    assign wr_ready  = (state_q == ST_LOAD);
    assign scrolling = (state_q == ST_SCROLL);
    assign char_bus  = bus_q;
    assign msg_len   = len_q;
    assign err       = err_q;

endmodule

// File: tb/tb_msg_writer.sv
// Directed bench for msg_writer with a reference model feeding a scoreboard.
module tb_msg_writer;
    import char_code_pkg::*;

    logic        clk = 1'b0;
    logic        reset, wr_valid, wr_last, tick, clear;
    logic [2:0]  wr_char;
    logic        wr_ready, scrolling, err;
    logic [23:0] char_bus;
    logic [3:0]  msg_len;

    always #5 clk = ~clk;

    msg_writer dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_char   (wr_char),
        .wr_last   (wr_last),
        .wr_ready  (wr_ready),
        .tick      (tick),
        .clear     (clear),
        .char_bus  (char_bus),
        .msg_len   (msg_len),
        .scrolling (scrolling),
        .err       (err)
    );

    typedef struct packed {
        logic [23:0] bus;
        logic [3:0]  len;
        logic        ready;
        logic        scroll;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [23:0] m_bus;
    logic [3:0]  m_len;
    logic        m_scroll;
    logic        m_err;
    int          checks = 0;
    int          errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle, predict, then compare the DUT against the oldest prediction
    task automatic step(input logic v, input logic [2:0] c, input logic l,
                        input logic t, input logic cl, input logic rst);
        exp_t e;
        logic [2:0] sc;
        @(negedge clk);
        wr_valid = v; wr_char = c; wr_last = l; tick = t; clear = cl; reset = rst;
        if (rst) begin
            m_bus = 24'h924924; m_len = 4'd0; m_scroll = 1'b0; m_err = 1'b0;
        end else if (cl) begin
            m_bus = 24'h924924; m_len = 4'd0; m_scroll = 1'b0;
        end else if (!m_scroll) begin
            if (v) begin
                sc = c;
`ifdef MSG_WRITER_CHECK_EN
                if (c > 3'b100) begin sc = 3'b100; m_err = 1'b1; end
`endif
                m_bus[3*(7-int'(m_len)) +: 3] = sc;
                m_len = m_len + 4'd1;
                if (l || m_len == 4'd8) m_scroll = 1'b1;
            end
        end else if (t) begin
            m_bus = {m_bus[20:0], m_bus[23:21]};
        end
        sb_q.push_back('{bus: m_bus, len: m_len, ready: !m_scroll, scroll: m_scroll, err: m_err});
        @(posedge clk);
        #1;
        checks++;
        assert (sb_q.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("char_bus", 32'(char_bus), 32'(e.bus));
            check_val("msg_len", 32'(msg_len), 32'(e.len));
            check_val("wr_ready", 32'(wr_ready), 32'(e.ready));
            check_val("scrolling", 32'(scrolling), 32'(e.scroll));
            check_val("err", 32'(err), 32'(e.err));
        end
    endtask

    task automatic wr(input logic [2:0] c, input logic l);
        step(1'b1, c, l, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_tick();
        step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_char = 3'b000; wr_last = 1'b0;
        tick = 1'b0; clear = 1'b0;
        m_bus = 24'h924924; m_len = 4'd0; m_scroll = 1'b0; m_err = 1'b0;

        // Reset state
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("reset_bus", 32'(char_bus), 32'h0092_4924);
        check_val("reset_len", 32'(msg_len), 32'd0);
        check_val("reset_ready", 32'(wr_ready), 32'd1);
        check_val("reset_scrolling", 32'(scrolling), 32'd0);
        idle();
        // tick ignored in LOAD
        do_tick();

        // HELLO, tick coincident with the final accept
        wr(CH_H, 1'b0);
        wr(CH_E, 1'b0);
        idle();
        wr(CH_L, 1'b0);
        wr(CH_L, 1'b0);
        step(1'b1, CH_O, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("hello_bus", 32'(char_bus), 32'h0005_2724);
        check_val("hello_len", 32'(msg_len), 32'd5);
        check_val("hello_scrolling", 32'(scrolling), 32'd1);
        check_val("hello_ready", 32'(wr_ready), 32'd0);

        // Writes ignored in SCROLL
        step(1'b1, CH_H, 1'b0, 1'b0, 1'b0, 1'b0);
        do_tick();
        check_val("rot1_bus", 32'(char_bus), 32'h0029_3920);
        for (int i = 0; i < 7; i++) begin
            if (i == 3) idle();
            do_tick();
        end
        check_val("rot8_bus", 32'(char_bus), 32'h0005_2724);

        // clear beats tick and wr_valid
        step(1'b1, CH_E, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("clear_bus", 32'(char_bus), 32'h0092_4924);
        check_val("clear_len", 32'(msg_len), 32'd0);
        check_val("clear_ready", 32'(wr_ready), 32'd1);

        // Eight writes fill the buffer; includes a code with no glyph
        wr(3'b011, 1'b0);
        wr(3'b010, 1'b0);
        wr(3'b111, 1'b0);
        wr(3'b001, 1'b0);
        wr(3'b000, 1'b0);
        wr(3'b100, 1'b0);
        wr(3'b110, 1'b0);
        wr(3'b101, 1'b0);
        check_val("full_len", 32'(msg_len), 32'd8);
        check_val("full_scrolling", 32'(scrolling), 32'd1);
        // 9th write refused
        wr(3'b001, 1'b1);
        do_tick();
        do_tick();

        // clear with a write: write not accepted that cycle
        step(1'b1, CH_L, 1'b0, 1'b0, 1'b1, 1'b0);
        // One-character message with wr_last on the first write
        wr(CH_O, 1'b1);
        check_val("short_len", 32'(msg_len), 32'd1);
        do_tick();
        do_tick();

        // Reset during SCROLL
        step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        check_val("reset2_bus", 32'(char_bus), 32'h0092_4924);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
